sram_result_reader: RTL and testbench

Read-back engine for the transform-coefficient SRAM. After the accelerator shell finishes writing a frame's 64 coefficients (four 4x4 blocks, 15-bit each, addresses 0..63), this block fetches them in address order into a small FIFO. The ARM processor pops them over the AHB slave port. It sits beside the accelerator shell on the AHB bus and owns the SRAM read port.

---
 rtl/sram_rd_pkg.sv | 36 +++
 rtl/sram_rd_fifo.sv | 61 ++++++
 rtl/sram_result_reader.sv | 168 ++++++++++++++++
 tb/tb_sram_result_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the coefficient SRAM read-back engine.
// SRAM_RD_SIGN_EXT_EN selects sign- instead of zero-extension of coefficients.
package sram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] SEL_CTRL = 3'b011;
  localparam logic [2:0] SEL_DATA = 3'b010;

  localparam int COEF_W = 15;

  // Status register layout: {22'd0, count[5:0], underflow, full, empty, done}
  localparam int ST_DONE_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_FULL_BIT  = 2;
  localparam int ST_UFLOW_BIT = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 6;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  function automatic logic [31:0] extend_coef(input logic [COEF_W-1:0] coef);
`ifdef SRAM_RD_SIGN_EXT_EN
    return {{(32-COEF_W){coef[COEF_W-1]}}, coef};
`else
    return {{(32-COEF_W){1'b0}}, coef};
`endif
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Show-ahead synchronous FIFO for coefficients; simultaneous push and pop
// are both honoured, and flush empties it in one cycle.
module sram_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 15
) (
  input  logic                     in_HCLK,
  input  logic                     in_HRESET,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == CNT_DEPTH);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge in_HCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_result_reader.sv
// Fetches a frame of coefficients from the transform SRAM into a FIFO and
// serves them over an AHB slave port. SRAM_RD_SIGN_EXT_EN picks sign extension.
module sram_result_reader
  import sram_rd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_WORDS  = 64,
  parameter logic [14:0] BASE_ADDR  = 15'd0
) (
  input  logic        in_HCLK,
  input  logic        in_HRESET,
  input  logic        in_HSEL,
  input  logic        in_HWRITE,
  input  logic [31:0] in_HADDR,
  input  logic [31:0] in_HWDATA,
  output logic [31:0] out_HRDATA,
  output logic        out_HREADY,
  input  logic        in_accel_done,
  output logic [14:0] out_ADDR_SRAM,
  output logic        out_RE_SRAM,
  input  logic [31:0] in_DATA_SRAM,
  output logic        out_interrupt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCW = $clog2(NUM_WORDS) + 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);

  state_t             state;
  logic               accel_done_q;
  logic [14:0]        addr_q;
  logic [WCW-1:0]     word_cnt;
  logic               done_flag, uflow_flag, rd_pending;

  logic               bus_acc, sel_ctrl, sel_data;
  logic               ctrl_wr, clear, start, busy;
  logic               data_rd, status_rd, rd_now;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [COEF_W-1:0]  fifo_rd_data;
  logic [CW-1:0]      fifo_count;
  logic [31:0]        status_word;

  // A waiting data read owns the bus until it completes.
  assign bus_acc   = in_HSEL & ~rd_pending;
  assign sel_ctrl  = (in_HADDR[31:29] == SEL_CTRL);
  assign sel_data  = (in_HADDR[31:29] == SEL_DATA);
  assign ctrl_wr   = bus_acc & in_HWRITE & sel_ctrl;
  assign clear     = ctrl_wr & in_HWDATA[CTRL_CLEAR_BIT];
  assign start     = ~clear & ((in_accel_done & ~accel_done_q) |
                               (ctrl_wr & in_HWDATA[CTRL_START_BIT]));
  assign busy      = (state == ISSUE) || (state == CAPTURE);
  assign data_rd   = bus_acc & ~in_HWRITE & sel_data;
  assign status_rd = bus_acc & ~in_HWRITE & sel_ctrl;
  assign rd_now    = data_rd | rd_pending;

  assign fifo_push = (state == CAPTURE);
  assign fifo_pop  = rd_now & ~fifo_empty;

  assign out_RE_SRAM   = (state == ISSUE) & ~fifo_full;
  assign out_ADDR_SRAM = addr_q;

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (COEF_W)
  ) u_fifo (
    .in_HCLK   (in_HCLK),
    .in_HRESET (in_HRESET),
    .flush     (clear),
    .push      (fifo_push),
    .push_data (in_DATA_SRAM[COEF_W-1:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    status_word = '0;
    status_word[ST_DONE_BIT]  = done_flag;
    status_word[ST_EMPTY_BIT] = fifo_empty;
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_UFLOW_BIT] = uflow_flag;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
  end

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      state         <= IDLE;
      accel_done_q  <= 1'b0;
      addr_q        <= BASE_ADDR;
      word_cnt      <= '0;
      done_flag     <= 1'b0;
      out_interrupt <= 1'b0;
    end else begin
      accel_done_q  <= in_accel_done;
      out_interrupt <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        addr_q    <= BASE_ADDR;
        word_cnt  <= '0;
        done_flag <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= ISSUE;
              addr_q    <= BASE_ADDR;
              word_cnt  <= '0;
              done_flag <= 1'b0;
            end
          end
          ISSUE: begin
            if (!fifo_full) state <= CAPTURE;
          end
          CAPTURE: begin
            if (word_cnt == LAST_WORD) begin
              state         <= DONE;
              done_flag     <= 1'b1;
              out_interrupt <= 1'b1;
            end else begin
              word_cnt <= word_cnt + WCNT_ONE;
              addr_q   <= addr_q + 15'd1;
              state    <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      out_HRDATA <= '0;
      out_HREADY <= 1'b0;
      rd_pending <= 1'b0;
      uflow_flag <= 1'b0;
    end else begin
      out_HRDATA <= '0;
      out_HREADY <= 1'b0;
      if (rd_now) begin
        if (!fifo_empty) begin
          out_HRDATA <= extend_coef(fifo_rd_data);
          out_HREADY <= 1'b1;
          rd_pending <= 1'b0;
        end else if (busy) begin
          rd_pending <= 1'b1;
        end else begin
          // Nothing can arrive: answer zero at once and record the underflow.
          out_HREADY <= 1'b1;
          rd_pending <= 1'b0;
          uflow_flag <= 1'b1;
        end
      end else if (bus_acc) begin
        out_HREADY <= 1'b1;
        if (status_rd) out_HRDATA <= status_word;
      end
      if (clear) uflow_flag <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{in_HADDR[28:0], in_HWDATA[31:2], in_DATA_SRAM[31:COEF_W]};

endmodule

// File: tb/tb_sram_result_reader.sv
// Directed bench for sram_result_reader with a behavioural SRAM holding addr+100.
module tb_sram_result_reader;

  localparam logic [31:0] CTRL_A = 32'h6000_0000;
  localparam logic [31:0] DATA_A = 32'h4000_0000;
`ifdef SRAM_RD_SIGN_EXT_EN
  localparam logic [31:0] EXT_4001 = 32'hFFFF_C001;
`else
  localparam logic [31:0] EXT_4001 = 32'h0000_4001;
`endif

  logic        in_HCLK = 1'b0;
  logic        in_HRESET;
  logic        in_HSEL, in_HWRITE;
  logic [31:0] in_HADDR, in_HWDATA;
  logic [31:0] out_HRDATA;
  logic        out_HREADY;
  logic        in_accel_done;
  logic [14:0] out_ADDR_SRAM;
  logic        out_RE_SRAM;
  logic [31:0] in_DATA_SRAM;
  logic        out_interrupt;

  logic [31:0] sram [64];
  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  sram_result_reader dut (
    .in_HCLK       (in_HCLK),
    .in_HRESET     (in_HRESET),
    .in_HSEL       (in_HSEL),
    .in_HWRITE     (in_HWRITE),
    .in_HADDR      (in_HADDR),
    .in_HWDATA     (in_HWDATA),
    .out_HRDATA    (out_HRDATA),
    .out_HREADY    (out_HREADY),
    .in_accel_done (in_accel_done),
    .out_ADDR_SRAM (out_ADDR_SRAM),
    .out_RE_SRAM   (out_RE_SRAM),
    .in_DATA_SRAM  (in_DATA_SRAM),
    .out_interrupt (out_interrupt)
  );

  always #5 in_HCLK = ~in_HCLK;

  always @(posedge in_HCLK) begin
    if (out_RE_SRAM) in_DATA_SRAM <= sram[out_ADDR_SRAM[5:0]];
  end

  always @(posedge in_HCLK) begin
    if (out_interrupt === 1'b1) irq_cnt <= irq_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    in_HSEL = 1'b1; in_HWRITE = 1'b1; in_HADDR = addr; in_HWDATA = data;
    @(negedge in_HCLK);
    in_HSEL = 1'b0; in_HWRITE = 1'b0; in_HADDR = '0; in_HWDATA = '0;
  endtask

  task automatic ahb_read(input string tag, input logic [31:0] addr,
                          output logic [31:0] data, output int waits);
    in_HSEL = 1'b1; in_HWRITE = 1'b0; in_HADDR = addr;
    @(negedge in_HCLK);
    in_HSEL = 1'b0; in_HADDR = '0;
    waits = 0;
    while (out_HREADY !== 1'b1 && waits < 50) begin
      @(negedge in_HCLK);
      waits++;
    end
    if (waits >= 50) check({tag, "_hready_timeout"}, {31'd0, out_HREADY}, 32'd1);
    data = out_HRDATA;
  endtask

  task automatic idle_cycles(input int n, output logic re_seen);
    re_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge in_HCLK);
      if (out_RE_SRAM !== 1'b0) re_seen = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          w;
    logic        re_seen;

    for (int i = 0; i < 64; i++) sram[i] = 32'(i + 100);
    in_HRESET = 1'b1; in_HSEL = 1'b0; in_HWRITE = 1'b0;
    in_HADDR = '0; in_HWDATA = '0; in_accel_done = 1'b0;
    @(negedge in_HCLK);

    // Reset values
    check("rst_hrdata", out_HRDATA, 32'd0);
    check("rst_hready", {31'd0, out_HREADY}, 32'd0);
    check("rst_addr",   {17'd0, out_ADDR_SRAM}, 32'd0);
    check("rst_re",     {31'd0, out_RE_SRAM}, 32'd0);
    check("rst_irq",    {31'd0, out_interrupt}, 32'd0);
    in_HRESET = 1'b0;
    @(negedge in_HCLK);
    ahb_read("st_reset", CTRL_A, d, w);
    check("st_reset", d, 32'h0000_0002);

    // Underflow in IDLE, then clear
    ahb_read("uflow", DATA_A, d, w);
    check("uflow_data",  d, 32'd0);
    check("uflow_nowait", 32'(w), 32'd0);
    ahb_read("st_uflow", CTRL_A, d, w);
    check("st_uflow", d, 32'h0000_000A);
    ahb_write(CTRL_A, 32'h2);
    ahb_read("st_clr", CTRL_A, d, w);
    check("st_after_clear", d, 32'h0000_0002);

    // Full frame started by the accelerator flag, popped as it arrives
    in_accel_done = 1'b1;
    @(negedge in_HCLK);
    in_accel_done = 1'b0;
    check("first_re",   {31'd0, out_RE_SRAM}, 32'd1);
    check("first_addr", {17'd0, out_ADDR_SRAM}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      ahb_read("f1", DATA_A, d, w);
      check($sformatf("f1_word%0d", i), d, 32'(i + 100));
    end
    check("f1_irq", 32'(irq_cnt), 32'd1);
    ahb_read("st_f1", CTRL_A, d, w);
    check("st_f1_done", d, 32'h0000_0003);

    // Stall with no pops, then drain
    ahb_write(CTRL_A, 32'h2);
    ahb_write(CTRL_A, 32'h1);
    idle_cycles(40, re_seen);
    check("stall_re",   {31'd0, out_RE_SRAM}, 32'd0);
    check("stall_addr", {17'd0, out_ADDR_SRAM}, 32'd8);
    ahb_read("st_stall", CTRL_A, d, w);
    check("st_stall_full", d, 32'h0000_0084);
    for (int i = 0; i < 64; i++) begin
      ahb_read("f2", DATA_A, d, w);
      check($sformatf("f2_word%0d", i), d, 32'(i + 100));
    end
    check("f2_irq", 32'(irq_cnt), 32'd2);
    ahb_read("st_f2", CTRL_A, d, w);
    check("st_f2_done", d, 32'h0000_0003);

    // Extension of bit 14; upper SRAM bits must be ignored
    ahb_write(CTRL_A, 32'h2);
    sram[0] = 32'hABCD_4001;
    ahb_write(CTRL_A, 32'h1);
    ahb_read("ext", DATA_A, d, w);
    check("ext_4001", d, EXT_4001);

    // Clear and start together while busy: clear wins
    ahb_write(CTRL_A, 32'h3);
    ahb_read("st_abort", CTRL_A, d, w);
    check("st_abort", d, 32'h0000_0002);
    idle_cycles(10, re_seen);
    check("abort_no_re", {31'd0, re_seen}, 32'd0);
    check("abort_addr",  {17'd0, out_ADDR_SRAM}, 32'd0);
    check("abort_irq",   32'(irq_cnt), 32'd2);
    ahb_write(CTRL_A, 32'h1);
    ahb_read("refetch0", DATA_A, d, w);
    check("refetch_w0", d, EXT_4001);
    ahb_read("refetch1", DATA_A, d, w);
    check("refetch_w1", d, 32'd101);

    // Reset mid-fetch after 20 words
    ahb_write(CTRL_A, 32'h2);
    ahb_write(CTRL_A, 32'h1);
    for (int i = 0; i < 20; i++) begin
      ahb_read("f3", DATA_A, d, w);
      check($sformatf("f3_word%0d", i), d, (i == 0) ? EXT_4001 : 32'(i + 100));
    end
    in_HRESET = 1'b1;
    #1;
    check("mid_rst_hrdata", out_HRDATA, 32'd0);
    check("mid_rst_hready", {31'd0, out_HREADY}, 32'd0);
    check("mid_rst_addr",   {17'd0, out_ADDR_SRAM}, 32'd0);
    check("mid_rst_re",     {31'd0, out_RE_SRAM}, 32'd0);
    check("mid_rst_irq",    {31'd0, out_interrupt}, 32'd0);
    @(negedge in_HCLK);
    @(negedge in_HCLK);
    in_HRESET = 1'b0;
    idle_cycles(10, re_seen);
    check("post_rst_no_re", {31'd0, re_seen}, 32'd0);
    check("post_rst_irq",   32'(irq_cnt), 32'd2);
    ahb_read("st_post_rst", CTRL_A, d, w);
    check("st_post_rst", d, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
